// File: rtl/softmax_pkg.sv
// Shared types, score width and saturating subtract for the softmax row-max stage.
package softmax_pkg;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} rowmax_state_e;

  localparam int SCORE_DW = 16;

  // The difference is formed one bit wider so any wrap into the sign bit is visible.
  function automatic logic signed [SCORE_DW-1:0] sat_sub(
    input logic signed [SCORE_DW-1:0] x,
    input logic signed [SCORE_DW-1:0] m
  );
    logic signed [SCORE_DW:0] diff;
    diff = {x[SCORE_DW-1], x} - {m[SCORE_DW-1], m};
    if (diff[SCORE_DW] != diff[SCORE_DW-1])
      return {diff[SCORE_DW], {(SCORE_DW-1){~diff[SCORE_DW]}}};
    return diff[SCORE_DW-1:0];
  endfunction

endpackage

// File: rtl/score_row_buf.sv
// One-row score buffer: flop array with a single write port and an asynchronous read port.
module score_row_buf
  import softmax_pkg::*;
#(
  parameter int DW    = SCORE_DW,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic signed [DW-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic signed [DW-1:0] rdata
);

  logic signed [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/softmax_rowmax_stage.sv
// Buffers one row of scores, tracks its maximum, then replays the row as sat(score - rowmax).
// DW must equal SCORE_DW because the shared saturating subtract is fixed at that width.
module softmax_rowmax_stage
  import softmax_pkg::*;
#(
  parameter int DW    = SCORE_DW,
  parameter int MAX_S = 256
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [15:0]          m_rows,
  input  logic [15:0]          s_tokens,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data,
  output logic                 out_last,
  output logic signed [DW-1:0] out_rowmax
);

  localparam int AW = $clog2(MAX_S);
  localparam logic [15:0] MAX_S16 = 16'(MAX_S);

  rowmax_state_e        state;
  logic [15:0]          m_lat;
  logic [15:0]          row_cnt;
  logic [AW:0]          s_lat;
  logic [AW:0]          wr_idx;
  logic [AW:0]          rd_idx;
  logic signed [DW-1:0] rowmax;
  logic signed [DW-1:0] rd_data_p0;
  logic                 in_fire;
  logic                 out_fire;
  logic                 bad_job;
  logic                 load_p0;

  assign in_ready = (state == FILL);
  assign busy     = (state == FILL) || (state == DRAIN);
  assign done     = (state == DONE);
  assign in_fire  = in_valid && (state == FILL);
  assign out_fire = out_valid && out_ready;
  assign bad_job  = (m_rows == 16'd0) || (s_tokens == 16'd0) || (s_tokens > MAX_S16);
  assign load_p0  = (state == DRAIN) && (rd_idx < s_lat) && (!out_valid || out_ready);

  score_row_buf #(
    .DW    (DW),
    .DEPTH (MAX_S),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (in_fire),
    .waddr (wr_idx[AW-1:0]),
    .wdata (in_data),
    .raddr (rd_idx[AW-1:0]),
    .rdata (rd_data_p0)
  );

  // Stage p0 -> output register: buffer read, subtract and saturate.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      m_lat      <= '0;
      s_lat      <= '0;
      row_cnt    <= '0;
      wr_idx     <= '0;
      rd_idx     <= '0;
      rowmax     <= '0;
      err        <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      out_rowmax <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m_lat   <= m_rows;
            s_lat   <= s_tokens[AW:0];
            row_cnt <= '0;
            wr_idx  <= '0;
            rd_idx  <= '0;
            if (bad_job) begin
              err   <= 1'b1;
              state <= DONE;
            end else begin
              err   <= 1'b0;
              state <= FILL;
            end
          end
        end
        FILL: begin
          if (in_fire) begin
            if ((wr_idx == '0) || (in_data > rowmax)) rowmax <= in_data;
            if (wr_idx == s_lat - 1'b1) begin
              rd_idx <= '0;
              state  <= DRAIN;
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_fire && out_last) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            row_cnt   <= row_cnt + 16'd1;
            if (row_cnt == m_lat - 16'd1) begin
              state <= DONE;
            end else begin
              wr_idx <= '0;
              state  <= FILL;
            end
          end else if (load_p0) begin
            out_data   <= sat_sub(rd_data_p0, rowmax);
            out_last   <= (rd_idx == s_lat - 1'b1);
            out_rowmax <= rowmax;
            out_valid  <= 1'b1;
            rd_idx     <= rd_idx + 1'b1;
          end else if (out_fire) begin
            out_valid <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
